// File: rtl/clarvi_soc_leds_pkg.sv
// Shared LED driver defaults: channel count, brightness resolution and level type.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the fade driver top and its per-channel PWM block.
package clarvi_soc_leds_pkg;

    localparam int LEDS_N_DEFAULT        = 10;
    localparam int LEDS_PWM_BITS_DEFAULT = 8;
    localparam int LED_LEVEL_MAX         = (1 << LEDS_PWM_BITS_DEFAULT) - 1;

    typedef logic [LEDS_PWM_BITS_DEFAULT-1:0] led_level_t;

    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/clarvi_soc_led_pwm_channel.sv
// One LED channel: brightness level ramps toward target on ramp_tick, PWM compare drives the pin.
// Level updates one cycle after its inputs; led is registered one cycle after level.
// No backpressure; fade_en low forces the level straight to target.
module clarvi_soc_led_pwm_channel
    import clarvi_soc_leds_pkg::*;
#(
    parameter int PWM_BITS = LEDS_PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] target,
    input  logic                fade_en,
    input  logic                ramp_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    // Target is only ever 0 or MAX, so stepping toward it cannot wrap or overshoot.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            if (!fade_en) begin
                level <= target;
            end else if (ramp_tick && (level < target)) begin
                level <= level + 1'b1;
            end else if (ramp_tick && (level > target)) begin
                level <= level - 1'b1;
            end
            // Full level is forced solid so the counter wrap never blinks a fully-on LED.
            led <= (level == MAX) | (level > pwm_cnt);
        end
    end

endmodule

// File: rtl/clarvi_soc_leds_fade_driver.sv
// LED fade driver between the PIO out_port and the board pins: per-LED PWM with smooth ramps.
// Bypass latency pattern_in -> led_out is 3 cycles; a full fade takes MAX ramp ticks.
// No backpressure; pattern_in is resampled every cycle.
module clarvi_soc_leds_fade_driver
    import clarvi_soc_leds_pkg::*;
#(
    parameter int N_LEDS   = LEDS_N_DEFAULT,
    parameter int PWM_BITS = LEDS_PWM_BITS_DEFAULT,
    parameter int PWM_DIV  = 4,
    parameter int RAMP_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_LEDS-1:0] pattern_in,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy
);

    localparam int PWM_PRE_W  = $clog2(PWM_DIV + 1);
    localparam int RAMP_PRE_W = $clog2(RAMP_DIV + 1);
    localparam logic [PWM_PRE_W-1:0]  PWM_LAST  = PWM_PRE_W'(PWM_DIV - 1);
    localparam logic [RAMP_PRE_W-1:0] RAMP_LAST = RAMP_PRE_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0]   MAX       = {PWM_BITS{1'b1}};

    logic [N_LEDS-1:0]     pattern_q;
    logic [PWM_PRE_W-1:0]  pwm_pre;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [RAMP_PRE_W-1:0] ramp_pre;
    logic                  pwm_tick;
    logic                  ramp_tick;
    logic                  any_diff;
    logic [PWM_BITS-1:0]   target [N_LEDS];
    logic [PWM_BITS-1:0]   level  [N_LEDS];

    assign pwm_tick  = (pwm_pre == PWM_LAST);
    assign ramp_tick = (ramp_pre == RAMP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            pwm_pre   <= '0;
            pwm_cnt   <= '0;
            ramp_pre  <= '0;
            busy      <= 1'b0;
        end else begin
            pattern_q <= pattern_in;
            pwm_pre   <= pwm_tick ? '0 : pwm_pre + 1'b1;
            ramp_pre  <= ramp_tick ? '0 : ramp_pre + 1'b1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            busy <= any_diff;
        end
    end

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < N_LEDS; i++) begin
            target[i] = pattern_q[i] ? MAX : '0;
            if (level[i] != target[i]) begin
                any_diff = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_LEDS; g++) begin : g_chan
        clarvi_soc_led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .target    (target[g]),
            .fade_en   (fade_en),
            .ramp_tick (ramp_tick),
            .pwm_cnt   (pwm_cnt),
            .level     (level[g]),
            .led       (led_out[g])
        );
    end

endmodule

// File: tb/tb_clarvi_soc_leds_fade_driver.sv
// Scoreboarded bench: a time-based reference model predicts led_out/busy for every clock edge.
module tb_clarvi_soc_leds_fade_driver;

    localparam int N    = 10;
    localparam int PB   = 4;
    localparam int MAXL = 15;
    localparam int PD   = 1;
    localparam int RD   = 4;

    typedef struct packed {
        logic [N-1:0] led;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pattern_in;
    logic         fade_en;
    logic [N-1:0] led_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t exp_q[$];

    // Reference state: integer brightness per LED, sampled pattern, edges since reset.
    int           lvl [N];
    logic [N-1:0] pq;
    int           t;

    clarvi_soc_leds_fade_driver #(
        .N_LEDS   (N),
        .PWM_BITS (PB),
        .PWM_DIV  (PD),
        .RAMP_DIV (RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pattern_in (pattern_in),
        .fade_en    (fade_en),
        .led_out    (led_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic [N-1:0] p, input logic f, output exp_t e);
        int  pwm;
        bit  tick;
        int  tgt;
        e = '0;
        if (r) begin
            for (int i = 0; i < N; i++) lvl[i] = 0;
            pq = '0;
            t  = 0;
        end else begin
            tick = ((t % RD) == RD - 1);
            pwm  = (t / PD) % (MAXL + 1);
            for (int i = 0; i < N; i++) begin
                tgt = pq[i] ? MAXL : 0;
                e.led[i] = (lvl[i] == MAXL) || (lvl[i] > pwm);
                if (lvl[i] != tgt) e.busy = 1'b1;
                if (!f) lvl[i] = tgt;
                else if (tick && lvl[i] < tgt) lvl[i] = lvl[i] + 1;
                else if (tick && lvl[i] > tgt) lvl[i] = lvl[i] - 1;
            end
            pq = p;
            t  = t + 1;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] p, input logic f);
        exp_t e;
        reset      = r;
        pattern_in = p;
        fade_en    = f;
        model_edge(r, p, f, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic r, input logic [N-1:0] p, input logic f, input int n);
        for (int k = 0; k < n; k++) step(r, p, f);
    endtask

    // Monitor: the DUT presents a new output every clock; compare it 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (led_out !== e.led) begin
                    errors++;
                    $display("FAIL led_out cycle %0d got %h want %h", cyc, led_out, e.led);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy cycle %0d got %b want %b", cyc, busy, e.busy);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] pat;
        logic         fe;
        logic         r;
        // Reset held with all-on pattern.
        run(1'b1, 10'h3FF, 1'b1, 3);
        // Bypass: pattern appears with 3-cycle latency, busy settles.
        run(1'b0, 10'h000, 1'b0, 3);
        run(1'b0, 10'h155, 1'b0, 12);
        // Clear, then full fade-up on LED0 and beyond saturation.
        run(1'b0, 10'h000, 1'b0, 4);
        run(1'b0, 10'h001, 1'b1, 80);
        // Fade down, reverse mid-ramp near level 7, finish at 0.
        run(1'b0, 10'h000, 1'b1, 32);
        run(1'b0, 10'h001, 1'b1, 30);
        run(1'b0, 10'h000, 1'b1, 70);
        // Bypass taking over mid-ramp at level ~5.
        run(1'b0, 10'h001, 1'b1, 22);
        run(1'b0, 10'h001, 1'b0, 5);
        // Reset mid-fade near level 9, then restart the same ramp from 0.
        run(1'b0, 10'h000, 1'b0, 3);
        run(1'b0, 10'h001, 1'b1, 38);
        run(1'b1, 10'h001, 1'b1, 1);
        run(1'b0, 10'h001, 1'b1, 70);
        // Randomised pattern, fade and occasional reset traffic.
        pat = 10'($urandom);
        fe  = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) pat = 10'($urandom);
            if ($urandom_range(0, 39) == 0) fe = ~fe;
            r = ($urandom_range(0, 199) == 0);
            step(r, pat, fe);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
